// File: rtl/mem_access_unit.sv
// mem_access_unit: sits between the CPU load/store datapath and a 32-bit
// word-addressed data RAM with a one-cycle synchronous read.
// Takes one byte-addressed load/store at a time. If an access crosses a word
// boundary, it is split into two word accesses; with ALLOW_MISALIGNED=0 such an
// access is rejected instead. Load data is returned aligned and sign- or
// zero-extended.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   req_valid/ready   request handshake, ready only while idle
//   req_addr          byte address
//   req_write         1 = store, 0 = load
//   req_size          0 byte, 1 half, 2 word, 3 illegal
//   req_unsigned      zero-extend byte/half loads
//   req_wdata         right-aligned store data
//   resp_valid        one-cycle completion pulse
//   resp_rdata        formatted load data (0 for stores/errors)
//   resp_error        illegal size or rejected misaligned access
//   memAddress        word address to RAM
//   memWriteData      lane-aligned write data
//   memWrite          RAM write enable
//   byteMask          per-lane write enable
//   memReadData       RAM read data, valid the cycle after the address
module mem_access_unit #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic        memWrite,
    output logic [3:0]  byteMask,
    input  logic [31:0] memReadData
);

    typedef enum logic [2:0] {StIdle, StAcc0, StRd0, StAcc1, StRd1, StResp} state_t;

    state_t      state;
    logic [31:0] acc_addr;
    logic [1:0]  acc_size;
    logic        acc_write;
    logic        acc_unsigned;
    logic [31:0] acc_wdata;
    logic [31:0] lo_word;      // first word of a split load

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic crosses_word(input logic [1:0] off, input logic [1:0] size);
        return ({1'b0, off} + size_bytes(size)) > 3'd4;
    endfunction

    // Byte enables over the two-word window {W1, W0}.
    function automatic logic [7:0] lane_mask_f(input logic [1:0] off, input logic [1:0] size);
        logic [7:0] m;
        case (size)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            default: m = 8'h0F;
        endcase
        return m << off;
    endfunction

    // Store data over the two-word window; lanes outside the access are zero.
    function automatic logic [63:0] lane_data_f(input logic [1:0] off, input logic [1:0] size,
                                                input logic [31:0] d);
        logic [63:0] v;
        case (size)
            2'd0:    v = {56'b0, d[7:0]};
            2'd1:    v = {48'b0, d[15:0]};
            default: v = {32'b0, d};
        endcase
        return v << {off, 3'b000};
    endfunction

    // words = {W1 data, W0 data}; bring byte 0 of the access down to bit 0.
    function automatic logic [31:0] format_load(input logic [63:0] words, input logic [1:0] off,
                                                input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = 32'(words >> {off, 3'b000});
        case (size)
            2'd0:    return uns ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'd1:    return uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    // While idle the incoming request drives the lane logic, afterwards the latched one.
    logic        idle;
    logic [1:0]  sel_off;
    logic [1:0]  sel_size;
    logic [31:0] sel_wdata;
    logic        sel_mis;
    logic [7:0]  lane_mask;
    logic [63:0] lane_data;
    logic [31:0] word0;
    logic [31:0] word1;

    assign idle      = (state == StIdle);
    assign req_ready = idle;

    always_comb begin
        sel_off   = idle ? req_addr[1:0] : acc_addr[1:0];
        sel_size  = idle ? req_size : acc_size;
        sel_wdata = idle ? req_wdata : acc_wdata;
        sel_mis   = crosses_word(sel_off, sel_size);
        lane_mask = lane_mask_f(sel_off, sel_size);
        lane_data = lane_data_f(sel_off, sel_size, sel_wdata);
        word0     = {2'b00, acc_addr[31:2]};
        word1     = {2'b00, acc_addr[31:2] + 30'd1};   // wraps modulo 2^30
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StIdle;
            acc_addr     <= '0;
            acc_size     <= '0;
            acc_write    <= 1'b0;
            acc_unsigned <= 1'b0;
            acc_wdata    <= '0;
            lo_word      <= '0;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_error   <= 1'b0;
            memAddress   <= '0;
            memWriteData <= '0;
            memWrite     <= 1'b0;
            byteMask     <= '0;
        end else begin
            // Outputs are registered for the state being entered; default is quiet.
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_error   <= 1'b0;
            memAddress   <= '0;
            memWriteData <= '0;
            memWrite     <= 1'b0;
            byteMask     <= '0;

            case (state)
                StIdle: begin
                    if (req_valid) begin
                        acc_addr     <= req_addr;
                        acc_size     <= req_size;
                        acc_write    <= req_write;
                        acc_unsigned <= req_unsigned;
                        acc_wdata    <= req_wdata;
                        if (req_size == 2'd3 || (sel_mis && !ALLOW_MISALIGNED)) begin
                            state      <= StResp;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                        end else begin
                            state      <= StAcc0;
                            memAddress <= {2'b00, req_addr[31:2]};
                            if (req_write) begin
                                memWrite     <= 1'b1;
                                byteMask     <= lane_mask[3:0];
                                memWriteData <= lane_data[31:0];
                            end
                        end
                    end
                end
                StAcc0: begin
                    if (acc_write) begin
                        if (sel_mis) begin
                            state        <= StAcc1;
                            memAddress   <= word1;
                            memWrite     <= 1'b1;
                            byteMask     <= lane_mask[7:4];
                            memWriteData <= lane_data[63:32];
                        end else begin
                            state      <= StResp;
                            resp_valid <= 1'b1;
                        end
                    end else begin
                        state      <= StRd0;
                        memAddress <= word0;
                    end
                end
                StRd0: begin
                    if (sel_mis) begin
                        state      <= StAcc1;
                        memAddress <= word1;
                        lo_word    <= memReadData;
                    end else begin
                        state      <= StResp;
                        resp_valid <= 1'b1;
                        resp_rdata <= format_load({32'b0, memReadData}, acc_addr[1:0],
                                                  acc_size, acc_unsigned);
                    end
                end
                StAcc1: begin
                    if (acc_write) begin
                        state      <= StResp;
                        resp_valid <= 1'b1;
                    end else begin
                        state      <= StRd1;
                        memAddress <= word1;
                    end
                end
                StRd1: begin
                    state      <= StResp;
                    resp_valid <= 1'b1;
                    resp_rdata <= format_load({memReadData, lo_word}, acc_addr[1:0],
                                              acc_size, acc_unsigned);
                end
                StResp:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int NC = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        memWrite;
    logic [3:0]  byteMask;
    logic [31:0] memReadData;

    // Second instance with misaligned accesses rejected.
    logic        s_req_valid;
    logic        s_req_ready;
    logic [31:0] s_req_addr;
    logic        s_req_write;
    logic [1:0]  s_req_size;
    logic        s_req_unsigned;
    logic [31:0] s_req_wdata;
    logic        s_resp_valid;
    logic [31:0] s_resp_rdata;
    logic        s_resp_error;
    logic [31:0] s_memAddress;
    logic [31:0] s_memWriteData;
    logic        s_memWrite;
    logic [3:0]  s_byteMask;
    logic [31:0] s_memReadData;
    logic        s_we_seen = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic chk_en = 1'b0;
    logic ram_load = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_unit #(.ALLOW_MISALIGNED(1'b1)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_error(resp_error), .memAddress(memAddress),
        .memWriteData(memWriteData), .memWrite(memWrite), .byteMask(byteMask),
        .memReadData(memReadData)
    );

    mem_access_unit #(.ALLOW_MISALIGNED(1'b0)) u_strict (
        .clk(clk), .reset(reset), .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_addr(s_req_addr), .req_write(s_req_write), .req_size(s_req_size),
        .req_unsigned(s_req_unsigned), .req_wdata(s_req_wdata), .resp_valid(s_resp_valid),
        .resp_rdata(s_resp_rdata), .resp_error(s_resp_error), .memAddress(s_memAddress),
        .memWriteData(s_memWriteData), .memWrite(s_memWrite), .byteMask(s_byteMask),
        .memReadData(s_memReadData)
    );

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b;
        b = i[7:0];
        case (i)
            1:       return 32'h44332211;
            2:       return 32'h88776655;
            'h40:    return 32'h80112233;
            default: return {b ^ 8'h5A, b, 8'hC3, b + 8'd7};
        endcase
    endfunction

    // RAM peripheral: 256 words, one-cycle synchronous read, byte-masked write.
    logic [31:0] ram [256];
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
        end else if (memWrite) begin
            for (int i = 0; i < 4; i++)
                if (byteMask[i]) ram[memAddress[7:0]][8*i +: 8] <= memWriteData[8*i +: 8];
        end
        memReadData <= ram[memAddress[7:0]];
    end

    always @(negedge clk) if (chk_en && s_memWrite) s_we_seen <= 1'b1;

    // Behavioural model: byte-addressed memory plus expected per-cycle outputs.
    logic [7:0]  mbytes  [1024];
    logic        e_busy  [NC];
    logic        e_valid [NC];
    logic        e_err   [NC];
    logic        e_we    [NC];
    logic [31:0] e_rdata [NC];
    logic [31:0] e_addr  [NC];
    logic [31:0] e_wdata [NC];
    logic [3:0]  e_mask  [NC];

    task automatic clear_exp(input int from, input int to);
        for (int i = from; i <= to && i < NC; i++) begin
            e_busy[i] = 1'b0; e_valid[i] = 1'b0; e_err[i] = 1'b0; e_we[i] = 1'b0;
            e_rdata[i] = '0; e_addr[i] = '0; e_wdata[i] = '0; e_mask[i] = '0;
        end
    endtask

    task automatic model_req(input int c, input logic [31:0] a, input logic w,
                             input logic [1:0] s, input logic u, input logic [31:0] d,
                             output int r);
        int n, nw, lane, j, t;
        logic [29:0] w0, wj;
        logic [31:0] ba, val;
        logic [3:0]  m  [2];
        logic [31:0] wd [2];
        if (s == 2'd3) begin
            r = c + 1;
            e_busy[r] = 1'b1; e_valid[r] = 1'b1; e_err[r] = 1'b1; e_rdata[r] = '0;
            return;
        end
        n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        w0 = a[31:2];
        nw = 1;
        val = '0;
        for (int i = 0; i < 2; i++) begin m[i] = '0; wd[i] = '0; end
        for (int k = 0; k < n; k++) begin
            ba = a + 32'(k);
            lane = int'(ba[1:0]);
            j = (ba[31:2] == w0) ? 0 : 1;
            if (j == 1) nw = 2;
            m[j][lane] = 1'b1;
            wd[j][8*lane +: 8] = d[8*k +: 8];
            val[8*k +: 8] = mbytes[ba[9:0]];
            if (w) mbytes[ba[9:0]] = d[8*k +: 8];
        end
        if (!w && n < 4 && !u && val[8*n-1]) val = val | ~((32'd1 << (8*n)) - 32'd1);
        if (w) begin
            for (int q = 0; q < nw; q++) begin
                t = c + 1 + q;
                wj = w0 + 30'(q);
                e_busy[t] = 1'b1; e_we[t] = 1'b1; e_mask[t] = m[q];
                e_wdata[t] = wd[q]; e_addr[t] = {2'b00, wj};
            end
            r = c + 1 + nw;
            val = '0;
        end else begin
            for (int q = 0; q < nw; q++) begin
                wj = w0 + 30'(q);
                for (int p = 0; p < 2; p++) begin
                    t = c + 1 + 2*q + p;
                    e_busy[t] = 1'b1; e_addr[t] = {2'b00, wj};
                end
            end
            r = c + 1 + 2*nw;
        end
        e_busy[r] = 1'b1; e_valid[r] = 1'b1; e_err[r] = 1'b0; e_rdata[r] = val;
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (chk_en && cyc < NC) begin
            checks++;
            if (req_ready !== ~e_busy[cyc] || resp_valid !== e_valid[cyc] ||
                resp_error !== e_err[cyc] || resp_rdata !== e_rdata[cyc] ||
                memWrite !== e_we[cyc] || byteMask !== e_mask[cyc] ||
                memAddress !== e_addr[cyc] || (e_we[cyc] && memWriteData !== e_wdata[cyc])) begin
                errors++;
                $display("FAIL cycle_%0d: got rdy=%b v=%b e=%b rd=%h we=%b m=%h a=%h wd=%h; want rdy=%b v=%b e=%b rd=%h we=%b m=%h a=%h wd=%h",
                         cyc, req_ready, resp_valid, resp_error, resp_rdata, memWrite, byteMask,
                         memAddress, memWriteData, ~e_busy[cyc], e_valid[cyc], e_err[cyc],
                         e_rdata[cyc], e_we[cyc], e_mask[cyc], e_addr[cyc], e_wdata[cyc]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic at_neg(input int n);
        int k = 0;
        @(negedge clk);
        while (cyc < n && k < 100) begin @(negedge clk); k++; end
        if (cyc != n) begin
            errors++;
            $display("FAIL at_neg: got cycle %0d, want %0d", cyc, n);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic w, input logic [1:0] s,
                         input logic u, input logic [31:0] d, output int c, output int r);
        int k = 0;
        @(posedge clk); #1;
        while (!req_ready && k < 50) begin @(posedge clk); #1; k++; end
        c = cyc; r = cyc;
        if (!req_ready) begin
            errors++;
            $display("FAIL issue_timeout: got ready=%b, want 1", req_ready);
            return;
        end
        req_valid = 1'b1; req_addr = a; req_write = w; req_size = s;
        req_unsigned = u; req_wdata = d;
        model_req(c, a, w, s, u, d, r);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic s_issue(input logic [31:0] a, input logic w, input logic [1:0] s,
                           output int c);
        int k = 0;
        @(posedge clk); #1;
        while (!s_req_ready && k < 50) begin @(posedge clk); #1; k++; end
        c = cyc;
        if (!s_req_ready) begin
            errors++;
            $display("FAIL s_issue_timeout: got ready=%b, want 1", s_req_ready);
            return;
        end
        s_req_valid = 1'b1; s_req_addr = a; s_req_write = w; s_req_size = s;
        s_req_unsigned = 1'b0; s_req_wdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        s_req_valid = 1'b0;
    endtask

    initial begin
        int c, r, c2, r2;
        logic [31:0] v;
        clear_exp(0, NC - 1);
        for (int wi = 0; wi < 256; wi++) begin
            v = init_word(wi);
            for (int b = 0; b < 4; b++) mbytes[4*wi + b] = v[8*b +: 8];
        end
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_size = '0;
        req_unsigned = 1'b0; req_wdata = '0;
        s_req_valid = 1'b0; s_req_addr = '0; s_req_write = 1'b0; s_req_size = '0;
        s_req_unsigned = 1'b0; s_req_wdata = '0; s_memReadData = 32'h12345678;
        repeat (3) @(posedge clk);
        #1; reset = 1'b0; ram_load = 1'b0; chk_en = 1'b1;

        @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_mem", {memAddress[27:0], byteMask}, 32'd0);
        chk("rst_we", {31'b0, memWrite}, 32'd0);

        // Aligned word store.
        issue(32'h104, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, c, r);
        at_neg(c + 1);
        chk("sw_addr", memAddress, 32'h41);
        chk("sw_mask", {28'b0, byteMask}, 32'hF);
        chk("sw_wdata", memWriteData, 32'hDEADBEEF);
        chk("sw_we", {31'b0, memWrite}, 32'd1);
        at_neg(c + 2);
        chk("sw_resp", {30'b0, resp_valid, resp_error}, 32'b10);

        // Byte load, signed then unsigned.
        issue(32'h103, 1'b0, 2'd0, 1'b0, 32'h0, c, r);
        at_neg(c + 3);
        chk("lb_rdata", resp_rdata, 32'hFFFFFF80);
        issue(32'h103, 1'b0, 2'd0, 1'b1, 32'h0, c, r);
        at_neg(c + 3);
        chk("lbu_rdata", resp_rdata, 32'h00000080);

        // Misaligned word load.
        issue(32'h6, 1'b0, 2'd2, 1'b0, 32'h0, c, r);
        at_neg(c + 1);
        chk("lw_mis_a0", memAddress, 32'h1);
        at_neg(c + 3);
        chk("lw_mis_a1", memAddress, 32'h2);
        at_neg(c + 5);
        chk("lw_mis_rdata", resp_rdata, 32'h66554433);

        // Misaligned half store, then read back the first word.
        issue(32'h7, 1'b1, 2'd1, 1'b0, 32'h0000ABCD, c, r);
        at_neg(c + 1);
        chk("sh_mis_acc0", {memAddress[23:0], 4'b0, byteMask}, {24'h1, 8'h08});
        chk("sh_mis_wd0", memWriteData, 32'hCD000000);
        at_neg(c + 2);
        chk("sh_mis_acc1", {memAddress[23:0], 4'b0, byteMask}, {24'h2, 8'h01});
        chk("sh_mis_wd1", memWriteData, 32'h000000AB);
        at_neg(c + 3);
        chk("sh_mis_resp", {31'b0, resp_valid}, 32'd1);
        issue(32'h4, 1'b0, 2'd2, 1'b0, 32'h0, c, r);
        at_neg(c + 3);
        chk("lw_readback", resp_rdata, 32'hCD332211);
        issue(32'h104, 1'b0, 2'd2, 1'b0, 32'h0, c, r);
        at_neg(c + 3);
        chk("lw_readback_sw", resp_rdata, 32'hDEADBEEF);

        // Illegal size.
        issue(32'h10, 1'b0, 2'd3, 1'b0, 32'h0, c, r);
        at_neg(c + 1);
        chk("size3_resp", {resp_rdata[29:0], resp_valid, resp_error}, 32'b11);

        // Model-only patterns: half loads, wrap-around store and load.
        issue(32'h3, 1'b0, 2'd1, 1'b0, 32'h0, c, r);
        issue(32'h2, 1'b0, 2'd1, 1'b1, 32'h0, c, r);
        issue(32'h101, 1'b0, 2'd1, 1'b0, 32'h0, c, r);
        issue(32'h105, 1'b1, 2'd0, 1'b0, 32'h0000007E, c, r);
        issue(32'h104, 1'b0, 2'd2, 1'b0, 32'h0, c, r);
        issue(32'hFFFFFFFF, 1'b1, 2'd2, 1'b0, 32'h01020304, c, r);
        issue(32'hFFFFFFFE, 1'b0, 2'd2, 1'b0, 32'h0, c, r);
        at_neg(c + 5);
        chk("lw_wrap_rdata", resp_rdata, 32'h02030400 | {24'h0, mbytes[10'h3FE]});

        // Reset during RD0 of a misaligned load: no W1 access, no response.
        issue(32'h6, 1'b0, 2'd2, 1'b0, 32'h0, c, r);
        @(posedge clk); #1;
        reset = 1'b1;
        clear_exp(c + 3, c + 20);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_mid_state", {resp_valid, memAddress[30:0]}, 32'd0);

        // Back-to-back byte stores, then read them back.
        issue(32'h0, 1'b1, 2'd0, 1'b0, 32'h00000011, c, r);
        issue(32'h1, 1'b1, 2'd0, 1'b0, 32'h00000022, c2, r2);
        chk("b2b_accept", 32'(c2), 32'(c + 3));
        issue(32'h0, 1'b0, 2'd1, 1'b0, 32'h0, c, r);
        at_neg(c + 3);
        chk("b2b_readback", resp_rdata, 32'h00002211);

        // Strict instance: misaligned and illegal requests are rejected.
        s_issue(32'h2, 1'b0, 2'd2, c);
        at_neg(c + 1);
        chk("strict_lw_mis", {s_resp_rdata[29:0], s_resp_valid, s_resp_error}, 32'b11);
        at_neg(c + 2);
        chk("strict_resp_once", {31'b0, s_resp_valid}, 32'd0);
        s_issue(32'h1, 1'b1, 2'd2, c);
        at_neg(c + 1);
        chk("strict_sw_mis", {s_resp_rdata[29:0], s_resp_valid, s_resp_error}, 32'b11);
        s_issue(32'h4, 1'b0, 2'd3, c);
        at_neg(c + 1);
        chk("strict_size3", {s_resp_rdata[29:0], s_resp_valid, s_resp_error}, 32'b11);
        s_issue(32'h4, 1'b0, 2'd2, c);
        at_neg(c + 3);
        chk("strict_lw_ok", s_resp_rdata, 32'h12345678);
        chk("strict_lw_ok_err", {30'b0, s_resp_valid, s_resp_error}, 32'b10);

        repeat (3) @(posedge clk);
        chk("strict_no_write", {31'b0, s_we_seen}, 32'd0);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
